// File: rtl/divider_32bit_if.sv
// Request/response bundle for the iterative 32-bit divider.
// The master issues start/kill with operands; the slave reports busy, valid and Result.
interface divider_32bit_if;
    logic        start;
    logic        kill;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        valid;
    logic [31:0] Result;

    modport master (output start, kill, op, A, B, input busy, valid, Result);
    modport slave  (input start, kill, op, A, B, output busy, valid, Result);
endinterface

// File: rtl/divider_32bit.sv
// Iterative restoring divider for RISC-V DIV/DIVU/REM/REMU: one quotient bit per cycle,
// with divide-by-zero and signed-overflow results produced directly without iterating.
module divider_32bit (
    input  logic             clk,
    input  logic             reset,
    divider_32bit_if.slave   dif
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    logic [4:0]         cnt;
    logic [1:0]         op_q;
    logic [31:0]        rem_q;
    logic [31:0]        dvd_q;
    logic [31:0]        dvs_q;
    logic               q_neg;
    logic               r_neg;
    logic               busy_q;
    logic               valid_q;
    logic [31:0]        result_q;

    function automatic logic [31:0] negate(input logic [31:0] v);
        logic signed [31:0] s;
        s = v;
        return 32'(-s);
    endfunction

    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? negate(v) : v;
    endfunction

    // Operand classification in IDLE
    logic sgn_op;
    logic div_zero;
    logic overflow;
    assign sgn_op   = ~dif.op[0];
    assign div_zero = (dif.B == 32'd0);
    assign overflow = sgn_op && (dif.A == 32'h8000_0000) && (dif.B == 32'hFFFF_FFFF);

    // One restoring step: shift in the next dividend bit, subtract via inverted divisor + 1
    logic [32:0] shifted;
    logic [33:0] trial;
    logic        carry;
    logic [31:0] rem_next;
    logic [31:0] quo_next;
    logic        unused_trial_bit;
    assign shifted          = {rem_q, dvd_q[31]};
    assign trial            = {1'b0, shifted} + {1'b0, ~{1'b0, dvs_q}} + 34'd1;
    assign carry            = trial[33];
    assign rem_next         = carry ? trial[31:0] : shifted[31:0];
    assign quo_next         = {dvd_q[30:0], carry};
    assign unused_trial_bit = trial[32];

    logic [31:0] final_result;
    assign final_result = op_q[1] ? (r_neg ? negate(rem_next) : rem_next)
                                  : (q_neg ? negate(quo_next) : quo_next);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 5'd0;
            op_q     <= 2'd0;
            rem_q    <= 32'd0;
            dvd_q    <= 32'd0;
            dvs_q    <= 32'd0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= 32'd0;
        end else if (dif.kill) begin
            state   <= IDLE;
            cnt     <= 5'd0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (dif.start) begin
                        busy_q <= 1'b1;
                        if (div_zero) begin
                            state    <= DONE;
                            valid_q  <= 1'b1;
                            result_q <= dif.op[1] ? dif.A : 32'hFFFF_FFFF;
                        end else if (overflow) begin
                            state    <= DONE;
                            valid_q  <= 1'b1;
                            result_q <= dif.op[1] ? 32'd0 : 32'h8000_0000;
                        end else begin
                            state <= BUSY;
                            cnt   <= 5'd0;
                            op_q  <= dif.op;
                            rem_q <= 32'd0;
                            dvd_q <= magnitude(dif.A, sgn_op);
                            dvs_q <= magnitude(dif.B, sgn_op);
                            q_neg <= sgn_op & (dif.A[31] ^ dif.B[31]);
                            r_neg <= sgn_op & dif.A[31];
                        end
                    end
                end
                BUSY: begin
                    rem_q <= rem_next;
                    dvd_q <= quo_next;
                    cnt   <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state    <= DONE;
                        valid_q  <= 1'b1;
                        result_q <= final_result;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign dif.busy   = busy_q;
    assign dif.valid  = valid_q;
    assign dif.Result = result_q;
endmodule

// File: tb/tb_divider_32bit.sv
// Bench for divider_32bit: directed cases, kill/reset scenarios and random operands
// compared against an arithmetic reference of RISC-V division semantics.
module tb_divider_32bit;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    divider_32bit_if dif ();

    divider_32bit dut (
        .clk   (clk),
        .reset (reset),
        .dif   (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
            2'd0:    return 32'(sa / sb);
            2'd1:    return a / b;
            2'd2:    return 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request at the current cycle (cycle 0) and follows it to its valid pulse.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int          cyc;
        int          lat_exp;
        logic [31:0] exp;
        logic        seen;
        exp     = ref_div(op, a, b);
        lat_exp = is_special(op, a, b) ? 1 : 33;
        seen    = 1'b0;
        dif.op    = op;
        dif.A     = a;
        dif.B     = b;
        dif.start = 1'b1;
        step();
        dif.start = 1'b0;
        cyc = 1;
        while (cyc < 40) begin
            if (cyc == 1) check({tag, "_busy"}, 32'(dif.busy), 32'd1);
            if (cyc == 5 && lat_exp == 33) begin
                dif.op    = ~op;
                dif.A     = $urandom;
                dif.B     = $urandom;
                dif.start = 1'b1;
            end else begin
                dif.start = 1'b0;
            end
            @(negedge clk);
            if (dif.valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            step();
            cyc++;
        end
        dif.start = 1'b0;
        check({tag, "_seen"}, 32'(seen), 32'd1);
        check({tag, "_lat"}, 32'(cyc), 32'(lat_exp));
        check({tag, "_res"}, dif.Result, exp);
        step();
        check({tag, "_idle"}, {30'd0, dif.busy, dif.valid}, 32'd0);
        check({tag, "_hold"}, dif.Result, exp);
    endtask

    initial begin
        int          stray;
        logic [31:0] last_res;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        checks = 0;
        errors = 0;
        reset     = 1'b1;
        dif.start = 1'b0;
        dif.kill  = 1'b0;
        dif.op    = 2'd0;
        dif.A     = 32'd0;
        dif.B     = 32'd0;
        step();
        step();
        check("rst_busy", 32'(dif.busy), 32'd0);
        check("rst_valid", 32'(dif.valid), 32'd0);
        check("rst_result", dif.Result, 32'd0);
        reset = 1'b0;
        step();

        run_op("divu_100_7", 2'd1, 32'd100, 32'd7);
        run_op("remu_100_7", 2'd3, 32'd100, 32'd7);
        run_op("div_m7_2", 2'd0, 32'hFFFF_FFF9, 32'd2);
        run_op("rem_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2);
        run_op("div_7_m2", 2'd0, 32'd7, 32'hFFFF_FFFE);
        run_op("divu_5_0", 2'd1, 32'd5, 32'd0);
        run_op("rem_5_0", 2'd2, 32'd5, 32'd0);
        run_op("div_ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_big", 2'd1, 32'h8000_0000, 32'hFFFF_FFFF);

        // Kill in cycle 10 of a DIVU 100/7
        last_res  = dif.Result;
        dif.op    = 2'd1;
        dif.A     = 32'd100;
        dif.B     = 32'd7;
        dif.start = 1'b1;
        step();
        dif.start = 1'b0;
        repeat (9) step();
        dif.kill = 1'b1;
        step();
        dif.kill = 1'b0;
        check("kill_busy", 32'(dif.busy), 32'd0);
        stray = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (dif.valid === 1'b1) stray++;
        end
        step();
        check("kill_no_valid", 32'(stray), 32'd0);
        check("kill_result_held", dif.Result, last_res);

        // Kill and start together in IDLE: request dropped
        dif.start = 1'b1;
        dif.kill  = 1'b1;
        step();
        dif.start = 1'b0;
        dif.kill  = 1'b0;
        check("kill_start_busy", 32'(dif.busy), 32'd0);
        step();

        // Reset in cycle 20 of an operation
        dif.op    = 2'd0;
        dif.A     = 32'hFFFF_FFF9;
        dif.B     = 32'd3;
        dif.start = 1'b1;
        step();
        dif.start = 1'b0;
        repeat (19) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_outputs", {dif.busy, dif.valid, 30'd0} | dif.Result, 32'd0);
        stray = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (dif.valid === 1'b1) stray++;
        end
        step();
        check("mid_rst_no_valid", 32'(stray), 32'd0);
        run_op("divu_ff_1", 2'd1, 32'hFFFF_FFFF, 32'd1);

        for (int n = 0; n < 24; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'(-$urandom_range(1, 15));
                3:       rb = {16'd0, 16'($urandom)};
                default: rb = $urandom;
            endcase
            if (n == 7) begin
                rop = 2'd2;
                ra  = 32'h8000_0000;
                rb  = 32'hFFFF_FFFF;
            end
            run_op($sformatf("rnd%0d", n), rop, ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/divider_32bit.md
DIVIDER_32BIT -- requirements
Module: divider_32bit

Interface
REQ-001 Parameters: none; datapath width fixed at 32 bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a new division; sampled only in IDLE.
REQ-005 kill  input  1  pipeline flush; aborts any operation in flight.
REQ-006 op  input  2  00 DIV (signed quotient), 01 DIVU, 10 REM (signed remainder), 11 REMU; equals RISC-V funct3[1:0].
REQ-007 A  input  32  dividend (rs1), sampled with start.
REQ-008 B  input  32  divisor (rs2), sampled with start.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 valid  output  1  one-cycle pulse: Result holds the final value.
REQ-011 Result  output  32  registered quotient or remainder selected by op.

Function
REQ-012 FSM states: IDLE, BUSY, DONE; encoding is free.
REQ-013 IDLE, start=1, kill=0: latch op, |A|, |B|, quotient sign (A[31]^B[31] for signed ops), remainder sign (A[31] for signed ops); then go to BUSY with iteration counter 0.
REQ-014 IDLE, start=1, B==0: skip BUSY and go directly to DONE; Result = 0xFFFFFFFF for DIV/DIVU, Result = A for REM/REMU.
REQ-015 IDLE, start=1, op=DIV/REM, A==0x80000000, B==0xFFFFFFFF: go directly to DONE; Result = 0x80000000 (DIV) or 0x00000000 (REM).
REQ-016 BUSY: restoring algorithm, one quotient bit per cycle, MSB first; 33-bit partial remainder shifted left with the next dividend bit, then trial subtraction of divisor.
REQ-017 Trial subtraction implemented as addition of the bit-inverted divisor with carry-in 1; a carry-out of 1 means non-negative: keep the difference and set quotient bit 1, otherwise restore and set 0.
REQ-018 BUSY lasts exactly 32 cycles (counter 0..31); the edge completing iteration 31 enters DONE and registers Result.
REQ-019 Sign correction at DONE entry: negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set; unsigned ops are never negated.
REQ-020 DONE: valid=1 for exactly one cycle; the next edge returns to IDLE unconditionally.
REQ-021 Latency: start in cycle 0 gives valid in cycle 33 (normal) or cycle 1 (REQ-014/015); the next start is accepted in the cycle after valid.
REQ-022 start while busy=1 is ignored; the captured operands and op are not disturbed.
REQ-023 kill=1 in any state: next state IDLE, valid stays 0 (including in DONE), and no result is produced.
REQ-024 kill and start in the same IDLE cycle: kill wins and the request is dropped.
REQ-025 Result holds its last value outside the valid cycle; consumers qualify it with valid.

Reset
REQ-026 reset=1 at any edge forces IDLE, busy=0, valid=0, Result=0, counter=0, internal remainder/quotient=0; it overrides start and kill.
REQ-027 reset mid-operation discards the operation; no valid pulse follows.

Verification
REQ-028 DIVU A=100, B=7, start in cycle 0 -> busy 1..33, valid in cycle 33, Result=14; repeat with REMU -> Result=2.
REQ-029 DIV A=0xFFFFFFF9 (-7), B=2 -> Result=0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1); DIV A=7, B=0xFFFFFFFE -> 0xFFFFFFFD.
REQ-030 DIVU A=5, B=0 -> valid in cycle 1, Result=0xFFFFFFFF; REM A=5, B=0 -> Result=5.
REQ-031 DIV A=0x80000000, B=0xFFFFFFFF -> valid in cycle 1, Result=0x80000000; REM -> 0.
REQ-032 DIVU 100/7 started, kill in cycle 10 -> busy=0 in cycle 11, no valid; start at cycle 5 (busy) ignored, original result unaffected.
REQ-033 reset asserted in cycle 20 of an operation -> all outputs 0 in the next cycle, no valid; a fresh DIVU 0xFFFFFFFF/1 then yields 0xFFFFFFFF.
